// File: rtl/key_debouncer_if.sv
// Key bus between the raw push-button pins and the debouncer.
// The master drives the raw keys and receives the clean levels.
interface key_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] clean;

  modport master (output raw, input clean);
  modport slave  (input raw, output clean);
endinterface

// File: rtl/key_debouncer.sv
// Multi-channel push-button conditioner.
// Each channel has a 2-flop synchroniser, then a stability-counter FSM that drives a registered clean level.
module key_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 250000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  key_debouncer_if.slave   kbus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             REL_LVL  = ACTIVE_LOW;

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_PEND   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_PEND = 2'd3;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             pressed_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;

    assign pressed_s     = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign kbus.clean[i] = clean_q;

    // Next-state logic; any reversal in a pending state discards the partial count.
    always_comb begin
      sync1_d = kbus.raw[i];
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      case (state_q)
        RELEASED: begin
          if (pressed_s) begin
            state_d = PRESS_PEND;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = RELEASED;
          end
        end
        PRESS_PEND: begin
          if (!pressed_s) begin
            state_d = RELEASED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
            clean_d = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        PRESSED: begin
          if (!pressed_s) begin
            state_d = RELEASE_PEND;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = PRESSED;
          end
        end
        RELEASE_PEND: begin
          if (pressed_s) begin
            state_d = PRESSED;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
            cnt_d   = CNT_ZERO;
            clean_d = 1'b0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
          clean_d = 1'b0;
        end
      endcase
    end

    // Synchroniser flops reset to the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= REL_LVL;
        sync2_q <= REL_LVL;
        state_q <= RELEASED;
        cnt_q   <= CNT_ZERO;
        clean_q <= 1'b0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
        clean_q <= clean_d;
      end
    end
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Multi-channel push-button conditioner for the DE1-SoC synth front end. Each channel synchronises a raw asynchronous key input into the `clk` domain and debounces it with a per-channel stability counter. It drives a clean, active-high, glitch-free level into the existing press/release pulse stage, which consumes one `clean` bit per key. All channels are independent and share only `clk` and `reset`.

## Interface
- `WIDTH`, default 4: number of key channels.
- `STABLE_CYCLES`, default 250000: consecutive cycles a new level must hold before `clean` follows it; 5 ms at 50 MHz. Legal range is ≥ 1.
- `ACTIVE_LOW`, default 1: 1 means a raw key reads 0 when pressed (DE1-SoC KEY). 0 means a raw key reads 1 when pressed.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high. It clears all state immediately, independent of `clk`.
- `raw`, input, `WIDTH`: asynchronous key inputs, one per channel.
- `clean`, output, `WIDTH`: registered debounced level per channel; 1 means pressed.

## Operation
- **Synchroniser.** Each channel has a 2-flop synchroniser on `raw[i]`.
  - Flops reset to the released raw level: 1 if `ACTIVE_LOW`, else 0.
  - `pressed_s[i]` is the second flop's output, inverted when `ACTIVE_LOW`=1.
- **Counter.** Each channel has a counter `cnt[i]` of width `$clog2(STABLE_CYCLES+1)`. It saturates and never wraps.
- **State machine.** Each channel has four states:
  - `RELEASED` (`clean`=0):
    - if `pressed_s`=1, go to `PRESS_PEND` with `cnt`=0;
    - otherwise stay.
  - `PRESS_PEND` (`clean`=0):
    - if `pressed_s`=0 (bounce), return to `RELEASED` with `cnt`=0;
    - if `pressed_s`=1 and `cnt`==`STABLE_CYCLES`-1, go to `PRESSED` and set `clean`<=1;
    - otherwise `cnt`<=`cnt`+1.
  - `PRESSED` (`clean`=1):
    - if `pressed_s`=0, go to `RELEASE_PEND` with `cnt`=0;
    - otherwise stay.
  - `RELEASE_PEND` (`clean`=1): mirror of `PRESS_PEND`.
    - `pressed_s`=1 returns to `PRESSED` with `cnt`=0;
    - a stable 0 at `cnt`==`STABLE_CYCLES`-1 goes to `RELEASED` and sets `clean`<=0.
- **Output.** `clean` is a flop updated on the same edge as the state transition, never decoded combinationally from state.
- **Bounce rejection.** Any reversal during a pending state discards the partial count. `clean` never changes for a pulse shorter than `STABLE_CYCLES` cycles at the synchroniser output.
- **Channel independence.** Channels share no state. Simultaneous activity on several channels produces fully independent results.

## Timing
- **Reset values.** While `reset` is asserted:
  - all `clean`=0;
  - all states are `RELEASED`;
  - all `cnt`=0;
  - synchroniser flops hold the released level.
- **Reset mid-debounce** discards the pending transition. After reset releases, a key still held pressed re-qualifies from `RELEASED` with full latency.
- **Latency.** Call edge 1 the first rising edge that samples a new raw level. Then:
  - edge 1: sync flop 1 captures it;
  - edge 2: sync flop 2 captures it;
  - edge 3: enters the pending state with `cnt`=0;
  - edge `STABLE_CYCLES`+3: `clean` changes.
  - Press and release latencies are identical.
- **`STABLE_CYCLES`=1.** The pending state lasts exactly one cycle; latency is 4 edges.
- **Rejection threshold.** A raw pulse that holds at the synchroniser output for ≤ `STABLE_CYCLES` cycles leaves `clean` unchanged. Measured at the raw input, a pulse shorter than `STABLE_CYCLES`+1 edge samples cannot propagate.
- **`clean` width.** `clean` changes at most once per qualified transition. Each change holds for ≥ `STABLE_CYCLES`+1 cycles, so the downstream pulse stage sees clean single edges.

## Test plan
Benches use `WIDTH`=4, `STABLE_CYCLES`=4, `ACTIVE_LOW`=1, with a 100-unit clock period.

1. **Reset state.** Assert `reset` for 2 cycles with `raw`=4'b1111, then release and hold for 10 cycles. Required: `clean`=4'b0000 throughout.
2. **Clean press and release.** Drive `raw[0]` to 0 just before edge 1 and hold. Required: `clean[0]` rises at edge 7, other bits stay 0. Then drive `raw[0]` back to 1. Required: `clean[0]` falls 7 edges later.
3. **Bounce rejection.** On `raw[1]`, toggle 0,1,0,1 every 2 cycles, then hold 0. Required: `clean[1]` stays 0 until 7 edges after the final 0 is first sampled, then rises once and stays 1.
4. **Short glitch.** Hold `raw[2]` low for exactly 3 cycles, then high. Required: `clean[2]` never leaves 0. Repeat with a 3-cycle high glitch while pressed. Required: `clean[2]` stays 1.
5. **Independent channels.** Press `raw[3]` and `raw[0]` on the same edge, and release `raw[0]` 2 cycles later. Required:
   - `clean[3]` rises at edge 7;
   - `clean[0]` never rises;
   - no cross-channel interference.
6. **Asynchronous reset mid-debounce.** Press `raw[0]` and assert `reset` between edges while in `PRESS_PEND`, keeping `raw[0]` low. Required:
   - `clean` is 0 immediately;
   - after reset deasserts, `clean[0]` rises 7 edges after the first post-reset edge.
